// File: rtl/enigma_rotor_bank.sv
// rtl/enigma_rotor_bank.sv - Enigma-style stepping rotor odometer with notch stepping, double-step, load and keypress count
module enigma_rotor_bank #(
    parameter int NUM_ROTORS = 3,
    parameter int POS_WIDTH = 5,
    parameter int MODULUS = 26,
    parameter logic [NUM_ROTORS*POS_WIDTH-1:0] NOTCHES = {5'd21, 5'd4, 5'd16},
    parameter bit DOUBLE_STEP = 1'b1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                            CLOCK_50,
    input  logic                            RESET_N,
    input  logic                            step_req,
    input  logic                            load,
    input  logic [NUM_ROTORS*POS_WIDTH-1:0] load_pos,
    output logic [NUM_ROTORS*POS_WIDTH-1:0] rotor_pos,
    output logic                            step_done,
    output logic                            wrap,
    output logic                            load_err,
    output logic [CNT_WIDTH-1:0]            key_count
);

    localparam int PW = POS_WIDTH;
    localparam logic [PW-1:0] MAX_POS = PW'(MODULUS - 1);

    typedef enum logic [1:0] {IDLE, STEP, WAIT_REL} state_t;

    state_t state, state_next;
    logic   do_step;

    logic [NUM_ROTORS-1:0]    adv;
    logic [NUM_ROTORS-1:0]    clamp;
    logic [NUM_ROTORS*PW-1:0] step_pos;
    logic [NUM_ROTORS*PW-1:0] load_val;
    logic                     wrap_next;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Load always parks the FSM in WAIT_REL so a key held across the load cannot step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) state_next = WAIT_REL;
                else if (step_req) state_next = STEP;
            end
            STEP:     state_next = WAIT_REL;
            WAIT_REL: begin
                if (!load && !step_req) state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        do_step = 1'b0;
        if (state == STEP && !load) do_step = 1'b1;
    end

    // Every advance decision looks only at pre-step positions; a double qualification is still one advance.
    genvar g;
    for (g = 0; g < NUM_ROTORS; g++) begin : g_rotor
        logic [PW-1:0] cur;
        logic [PW-1:0] fld;
        assign cur = rotor_pos[g*PW +: PW];
        assign fld = load_pos[g*PW +: PW];

        if (g == 0) begin : g_fast
            assign adv[g] = 1'b1;
        end else if (DOUBLE_STEP && g <= NUM_ROTORS - 2) begin : g_mid
            assign adv[g] = (rotor_pos[(g-1)*PW +: PW] == NOTCHES[(g-1)*PW +: PW]) ||
                            (cur == NOTCHES[g*PW +: PW]);
        end else begin : g_plain
            assign adv[g] = (rotor_pos[(g-1)*PW +: PW] == NOTCHES[(g-1)*PW +: PW]);
        end

        assign step_pos[g*PW +: PW] = !adv[g]        ? cur :
                                      (cur == MAX_POS) ? '0 : cur + PW'(1);
        assign clamp[g]             = 32'(fld) >= MODULUS;
        assign load_val[g*PW +: PW] = clamp[g] ? '0 : fld;
    end

    assign wrap_next = adv[NUM_ROTORS-1] && (rotor_pos[(NUM_ROTORS-1)*PW +: PW] == MAX_POS);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rotor_pos <= '0;
            key_count <= '0;
            step_done <= 1'b0;
            wrap      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            step_done <= 1'b0;
            wrap      <= 1'b0;
            load_err  <= 1'b0;
            if (load) begin
                rotor_pos <= load_val;
                key_count <= '0;
                load_err  <= |clamp;
            end else if (do_step) begin
                rotor_pos <= step_pos;
                key_count <= key_count + CNT_WIDTH'(1);
                step_done <= 1'b1;
                wrap      <= wrap_next;
            end
        end
    end

endmodule
